// File: rtl/audio_pkg.sv
// Shared audio-path constants and the serializer state encoding.
// Used by both the PDM capture and PDM playback blocks.
package audio_pkg;

  localparam int PDM_WORD_WIDTH = 16;
  localparam int DEF_CLK_DIV    = 100;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STARVED
  } ser_state_t;

endpackage

// File: rtl/tick_gen.sv
// Bit-rate divider: one-cycle tick every CLK_DIV clocks while enabled.
// Held at zero when disabled so the first tick is a full period away.
module tick_gen
  import audio_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (!enable) begin
      count_q <= '0;
    end else if (count_q == LAST) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

  assign tick = enable && (count_q == LAST);

endmodule

// File: rtl/pdm_serializer.sv
// PDM playback serializer: words in via valid/ready, MSB-first bits out.
// A one-word holding register lets the reader prefetch during shifting.
module pdm_serializer
  import audio_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int WORD_WIDTH = PDM_WORD_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  pdm_o,
  output logic                  amp_en_o,
  output logic                  done,
  output logic                  underrun
);

  localparam int CNT_W = $clog2(WORD_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT =
    CNT_W'(WORD_WIDTH - 1);

  ser_state_t state_q;
  ser_state_t state_d;

  logic [WORD_WIDTH-1:0] shift_q;
  logic [WORD_WIDTH-1:0] shift_d;
  logic [WORD_WIDTH-1:0] hold_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;

  logic pdm_q;
  logic pdm_d;
  logic full_q;
  logic done_q;
  logic underrun_q;
  logic amp_q;
  logic tick;
  logic load;
  logic starve;
  logic xfer;

  tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  assign xfer = data_valid & ~full_q;

  // Load decisions look only at the registered full flag, so a word
  // accepted in a load-tick cycle waits for the next word boundary.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    pdm_d   = pdm_q;
    load    = 1'b0;
    starve  = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      shift_d = '0;
      cnt_d   = '0;
      pdm_d   = 1'b0;
    end else if (tick) begin
      unique case (state_q)
        IDLE: begin
          pdm_d = 1'b0;
          load  = full_q;
        end
        RUN: begin
          if (cnt_q != '0) begin
            pdm_d   = shift_q[WORD_WIDTH-1];
            shift_d = {shift_q[WORD_WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q - CNT_W'(1);
          end else if (full_q) begin
            load = 1'b1;
          end else begin
            starve  = 1'b1;
            state_d = STARVED;
            pdm_d   = ~pdm_q;
          end
        end
        STARVED: begin
          if (full_q) begin
            load = 1'b1;
          end else begin
            pdm_d = ~pdm_q;
          end
        end
        default: begin
          state_d = IDLE;
          pdm_d   = 1'b0;
        end
      endcase
    end

    // The load tick already emits the new word's MSB.
    if (load) begin
      state_d = RUN;
      pdm_d   = hold_q[WORD_WIDTH-1];
      shift_d = {hold_q[WORD_WIDTH-2:0], 1'b0};
      cnt_d   = LAST_BIT;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      pdm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      pdm_q   <= pdm_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else if (load) begin
      full_q <= 1'b0;
    end else if (xfer) begin
      hold_q <= data_in;
      full_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      amp_q      <= 1'b0;
    end else begin
      done_q     <= load;
      underrun_q <= starve;
      amp_q      <= enable;
    end
  end

  assign data_ready = ~full_q;
  assign pdm_o      = pdm_q;
  assign amp_en_o   = amp_q;
  assign done       = done_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_pdm_serializer.sv
// Directed bench for pdm_serializer at CLK_DIV=4 and CLK_DIV=100.
module tb_pdm_serializer;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [15:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic        pdm_o;
  logic        amp_en_o;
  logic        done;
  logic        underrun;

  logic        en100;
  logic [15:0] din100;
  logic        dv100;
  logic        rdy100;
  logic        pdm100;
  logic        amp100;
  logic        done100;
  logic        und100;

  int errors = 0;
  int checks = 0;

  pdm_serializer #(
    .CLK_DIV    (4),
    .WORD_WIDTH (16)
  ) u_dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .pdm_o      (pdm_o),
    .amp_en_o   (amp_en_o),
    .done       (done),
    .underrun   (underrun)
  );

  pdm_serializer #(
    .CLK_DIV    (100),
    .WORD_WIDTH (16)
  ) u_dut100 (
    .clock      (clock),
    .reset      (reset),
    .enable     (en100),
    .data_in    (din100),
    .data_valid (dv100),
    .data_ready (rdy100),
    .pdm_o      (pdm100),
    .amp_en_o   (amp100),
    .done       (done100),
    .underrun   (und100)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk1(input string tag,
                      input logic obs,
                      input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag,
                         input int obs,
                         input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done_bp(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      chk1({tag, "_ready_low"}, data_ready, 1'b0);
      @(negedge clock);
      n++;
    end
    chk1({tag, "_done_seen"}, done, 1'b1);
  endtask

  // Two words pushed with valid held; checks gapless output.
  task automatic run_pair(input logic [15:0] w1,
                          input logic [15:0] w2,
                          input string tag);
    logic expb;
    enable     = 1'b1;
    data_in    = w1;
    data_valid = 1'b1;
    @(negedge clock);
    data_in = w2;
    chk1({tag, "_full"}, data_ready, 1'b0);
    wait_done_bp(tag);
    chk1({tag, "_ready_at_load"}, data_ready, 1'b1);
    for (int off = 0; off <= 128; off++) begin
      if (off > 0) @(negedge clock);
      if (off == 1) begin
        chk1({tag, "_w2_held"}, data_ready, 1'b0);
        data_valid = 1'b0;
      end
      if (off < 128 && (off % 4 == 0 || off % 4 == 3)) begin
        if (off < 64) expb = w1[15 - off / 4];
        else expb = w2[15 - (off - 64) / 4];
        chk1({tag, "_pdm"}, pdm_o, expb);
      end
      chk1({tag, "_done"}, done, (off == 0 || off == 64));
      chk1({tag, "_underrun"}, underrun, (off == 128));
    end
  endtask

  initial begin
    logic [15:0] w;
    int n;

    reset      = 1'b0;
    enable     = 1'b0;
    data_in    = '0;
    data_valid = 1'b0;
    en100      = 1'b0;
    din100     = '0;
    dv100      = 1'b0;

    #1 reset = 1'b1;
    #2;
    chk1("rst_ready", data_ready, 1'b1);
    chk1("rst_pdm", pdm_o, 1'b0);
    chk1("rst_amp", amp_en_o, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_underrun", underrun, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Single word, then starvation toggling.
    w          = 16'hA5F0;
    enable     = 1'b1;
    data_in    = w;
    data_valid = 1'b1;
    @(negedge clock);
    data_valid = 1'b0;
    chk1("t1_full", data_ready, 1'b0);
    chk1("t1_amp", amp_en_o, 1'b1);
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk_int("t1_latency", n, 3);
    for (int off = 0; off <= 72; off++) begin
      if (off > 0) @(negedge clock);
      if (off < 64 && (off % 4 == 0 || off % 4 == 3))
        chk1("t1_pdm", pdm_o, w[15 - off / 4]);
      if (off >= 64 && off % 4 == 0)
        chk1("t1_silence", pdm_o, ((off - 64) / 4) % 2 == 0);
      chk1("t1_done", done, off == 0);
      chk1("t1_underrun", underrun, off == 64);
    end
    enable = 1'b0;
    @(negedge clock);
    chk1("t1_dis_pdm", pdm_o, 1'b0);
    chk1("t1_dis_amp", amp_en_o, 1'b0);

    run_pair(16'hFFFF, 16'h0000, "b2b");
    run_pair(16'h1234, 16'hC3A5, "bp");

    // Enable dropped mid-word with a second word held.
    w          = 16'h8001;
    data_in    = w;
    data_valid = 1'b1;
    @(negedge clock);
    data_in = 16'hC001;
    wait_done_bp("en");
    for (int off = 0; off <= 33; off++) begin
      if (off > 0) @(negedge clock);
      if (off == 1) data_valid = 1'b0;
      if (off % 4 == 0)
        chk1("en_pdm", pdm_o, w[15 - off / 4]);
      chk1("en_done", done, off == 0);
    end
    enable = 1'b0;
    @(negedge clock);
    chk1("en_off_pdm", pdm_o, 1'b0);
    chk1("en_off_amp", amp_en_o, 1'b0);
    chk1("en_off_held", data_ready, 1'b0);
    repeat (6) begin
      @(negedge clock);
      chk1("en_off_quiet", pdm_o, 1'b0);
      chk1("en_off_nodone", done, 1'b0);
    end
    w      = 16'hC001;
    enable = 1'b1;
    n      = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk_int("en_relatency", n, 4);
    for (int off = 0; off <= 64; off++) begin
      if (off > 0) @(negedge clock);
      if (off < 64 && off % 4 == 0)
        chk1("en_re_pdm", pdm_o, w[15 - off / 4]);
      chk1("en_re_underrun", underrun, off == 64);
    end

    // Asynchronous reset while shifting with a word held.
    data_in    = 16'hFFFF;
    data_valid = 1'b1;
    @(negedge clock);
    data_in = 16'h1234;
    wait_done_bp("rm");
    for (int off = 0; off <= 10; off++) begin
      if (off > 0) @(negedge clock);
      if (off == 1) begin
        chk1("rm_full", data_ready, 1'b0);
        data_valid = 1'b0;
      end
    end
    chk1("rm_pdm_pre", pdm_o, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk1("rm_ready", data_ready, 1'b1);
    chk1("rm_pdm", pdm_o, 1'b0);
    chk1("rm_amp", amp_en_o, 1'b0);
    chk1("rm_done", done, 1'b0);
    chk1("rm_underrun", underrun, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    repeat (8) begin
      @(negedge clock);
      chk1("rm_idle_pdm", pdm_o, 1'b0);
      chk1("rm_idle_done", done, 1'b0);
      chk1("rm_idle_und", underrun, 1'b0);
    end
    chk1("rm_post_ready", data_ready, 1'b1);
    chk1("rm_post_amp", amp_en_o, 1'b1);

    // Full-rate divider: one word of ones lasts 1600 clocks.
    en100  = 1'b1;
    din100 = 16'hFFFF;
    dv100  = 1'b1;
    @(negedge clock);
    dv100 = 1'b0;
    chk1("d100_full", rdy100, 1'b0);
    n = 0;
    while (pdm100 !== 1'b1 && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk1("d100_start", pdm100, 1'b1);
    chk1("d100_done", done100, 1'b1);
    chk1("d100_amp", amp100, 1'b1);
    n = 0;
    while (pdm100 === 1'b1 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk_int("d100_ones", n, 1600);
    chk1("d100_underrun", und100, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pdm_serializer.md
# pdm_serializer

Transmit-side counterpart of the microphone capture path. It accepts 16-bit PDM words from the playback buffer through a valid/ready handshake and shifts them out MSB-first, one bit per bit-tick, on the board's mono audio output. An internal divider derives the 1 MHz bit rate from the 100 MHz system clock. A one-word holding register lets the upstream reader fetch the next word while the current one is shifting.

## Interface
- `CLK_DIV`, default 100: system clocks per output bit (100 MHz / 100 = 1 MHz); must be ≥2.
- `WORD_WIDTH`, default 16: bits per word.
- `clock` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-high; all state cleared immediately.
- `enable` in 1: playback enable; low = stop and flush the shifter.
- `data_in` in WORD_WIDTH: PDM word; bit 15 is transmitted first.
- `data_valid` in 1: `data_in` valid.
- `data_ready` out 1: holding register empty; transfer occurs when `data_valid && data_ready` at a rising edge.
- `pdm_o` out 1: serial PDM bit to the audio amplifier, registered.
- `amp_en_o` out 1: amplifier shutdown-bar; registered copy of `enable`.
- `done` out 1: one-cycle pulse when a word moves from holding into the shifter.
- `underrun` out 1: one-cycle pulse when the shifter empties at a tick while in RUN with no word held.

## Operation
- Reset values: `data_ready`=1, `pdm_o`=0, `amp_en_o`=0, `done`=0, `underrun`=0; divider=0; bit count=0; holding empty; state IDLE.
- Divider: counts 0..CLK_DIV-1 while `enable`=1. `tick` is high for the cycle in which the count is CLK_DIV-1. The divider is held at 0 while `enable`=0.
- Holding register: on a transfer it latches `data_in` and sets full. `data_ready` = not full. The holding register is not flushed by `enable`=0.
- States:
  - IDLE: `pdm_o`=0; shifter empty.
    - If `tick` and holding full: load into the shifter, pulse `done`, go to RUN.
  - RUN: on each `tick`, `pdm_o` ← shifter MSB, shift left, and decrement the bit count.
    - When the count reaches 0 at a tick: if holding is full, load it the same tick (gapless), output its MSB, and pulse `done`.
    - Otherwise, pulse `underrun` and go to STARVED.
  - STARVED: `pdm_o` toggles on every tick (50% density, i.e. silence). On a tick with holding full, load the word and return to RUN.
- A word loaded into the shifter outputs exactly WORD_WIDTH bits, one per tick.
- `enable` falling, from any state: shifter and bit count clear, state goes to IDLE, and `pdm_o` goes to 0 on the next edge.
- Loading uses the registered holding flag only. A transfer in the same cycle as a load tick is held for the next word boundary and never merged.

## Timing
- Bit period is exactly CLK_DIV clocks. `pdm_o` changes only on the edge that ends a tick cycle.
- First bit latency: the holding register fills at edge E. The first `pdm_o` bit appears after the first tick following E, at most CLK_DIV+1 clocks later.
- `data_ready` rises on the edge that loads the shifter, the same edge on which `done` pulses. `done` and `underrun` are never high in the same cycle.
- With `data_valid` held high continuously, the stream is gapless: one `done` every WORD_WIDTH×CLK_DIV clocks.
- `amp_en_o` follows `enable` with 1 cycle of latency.

## Structure
- Package `audio_pkg` holds:
  - the `WORD_WIDTH` and default `CLK_DIV` constants, shared with the deserializer;
  - the state enum `ser_state_t` {IDLE, RUN, STARVED}.
- Sub-module `tick_gen`: parameterized divider with `clock`, `reset`, `enable` inputs and a `tick` output. It is reused by the capture path.

## Test plan
All scenarios run with CLK_DIV=4 unless noted.
- Reset mid-word: assert `reset` asynchronously while shifting. All outputs take their reset values immediately; after release, `data_ready`=1 and `pdm_o`=0.
- Single word 16'hA5F0, `enable`=1: `pdm_o` is 1010 0101 1111 0000, each bit held 4 clocks. One `done` pulse, then one `underrun` pulse, then `pdm_o` toggles every 4 clocks.
- Back-to-back words 16'hFFFF then 16'h0000 with `data_valid` held: 64 clocks of 1 then 64 clocks of 0 with no gap. Two `done` pulses 64 clocks apart, no `underrun`.
- Backpressure: present a second word while the holding register is full. `data_ready`=0 until the first word loads; the second word is transmitted intact after the first.
- `enable` dropped at bit 7 of 16'h8001: `pdm_o`=0 on the next edge. The held word is retained; on re-enable it transmits from its MSB.
- With CLK_DIV=100, one 16'hFFFF word: exactly 1600 clocks of `pdm_o`=1.
